// File: rtl/non_restoring_divisor_pkg.sv
// Shared types for the non-restoring divider.
// Optional feature macro: NON_RESTORING_DIVISOR_ZERO_BYPASS_EN.
package non_restoring_divisor_pkg;

    localparam int NRD_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } nrd_state_t;

endpackage

// File: rtl/nrd_addsub.sv
// WIDTH+1-bit add/subtract of the divisor against the partial remainder.
// Optional feature macro: NON_RESTORING_DIVISOR_ZERO_BYPASS_EN (not used here).
module nrd_addsub #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH:0]   y
);

    logic [WIDTH:0] bx;

    assign bx = {1'b0, b};
    assign y  = sub ? (a - bx) : (a + bx);

endmodule

// File: rtl/non_restoring_divisor.sv
// Radix-2 non-restoring unsigned divider, one quotient bit per clock.
// Optional feature macro: NON_RESTORING_DIVISOR_ZERO_BYPASS_EN (divide-by-zero shortcut).
module non_restoring_divisor
    import non_restoring_divisor_pkg::*;
#(
    parameter int WIDTH = NRD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    nrd_state_t       state;
    nrd_state_t       state_nx;
    logic             start_q;
    logic             launch;
    logic             byp;
    logic [WIDTH:0]   p;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   p_sh;
    logic [WIDTH:0]   as_a;
    logic [WIDTH:0]   as_y;
    logic             as_sub;
    logic [WIDTH-1:0] rem_fix;

    assign launch = start & ~start_q &
                    ((state == IDLE) | (state == DONE));

`ifdef NON_RESTORING_DIVISOR_ZERO_BYPASS_EN
    assign byp = launch & (divisor == '0);
`else
    assign byp = 1'b0;
`endif

    // Same adder does the RUN step and the final sign correction
    assign p_sh    = {p[WIDTH-1:0], q[WIDTH-1]};
    assign as_a    = (state == FIX) ? p : p_sh;
    assign as_sub  = (state == RUN) & ~p[WIDTH];
    assign rem_fix = p[WIDTH] ? as_y[WIDTH-1:0] : p[WIDTH-1:0];

    nrd_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a   (as_a),
        .b   (d),
        .sub (as_sub),
        .y   (as_y)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (launch) state_nx = byp ? DONE : RUN;
            RUN:  if (cnt == LAST) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: if (launch) state_nx = byp ? DONE : RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q   <= 1'b0;
            p         <= '0;
            q         <= '0;
            d         <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
        end else begin
            start_q <= start;
            if (launch) begin
                d    <= divisor;
                p    <= '0;
                q    <= dividend;
                cnt  <= '0;
                done <= 1'b0;
                if (byp) begin
                    quotient  <= '1;
                    remainder <= dividend;
                end
            end else begin
                unique case (state)
                    RUN: begin
                        p   <= as_y;
                        q   <= {q[WIDTH-2:0], ~as_y[WIDTH]};
                        cnt <= cnt + 1'b1;
                    end
                    FIX: begin
                        quotient  <= q;
                        remainder <= rem_fix;
                    end
                    DONE:    done <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_non_restoring_divisor.sv
// Directed and random checks of the non-restoring divider.
// Optional feature macro: NON_RESTORING_DIVISOR_ZERO_BYPASS_EN.
module tb_non_restoring_divisor;

    localparam int W   = 64;
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         done;

    int total = 0;
    int bad   = 0;

    non_restoring_divisor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef NON_RESTORING_DIVISOR_ZERO_BYPASS_EN
        if (b == '0) return 1;
`endif
        return LAT;
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        int n;
        eq = (b == '0) ? '1 : a / b;
        er = (b == '0) ? a : a % b;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_done_low"}, W'(done), W'(0));
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, W'(n), W'(exp_lat(b)));
        chk({tag, "_quo"}, quotient, eq);
        chk({tag, "_rem"}, remainder, er);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", W'(done), W'(0));
        chk("rst_quo", quotient, '0);
        chk("rst_rem", remainder, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_op(64'd100, 64'd7, "d100_7");
        run_op(64'd5, '1, "d5_max");
        run_op('1, 64'd1, "max_1");
        run_op(64'h1234, 64'd0, "div0");
        run_op(64'd0, 64'd3, "zero_3");
        run_op('1, '1, "max_max");
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, "hi_hi1");

        // Abort mid-operation
        @(negedge clk);
        dividend = 64'd1000;
        divisor  = 64'd9;
        start    = 1'b1;
        repeat (20) @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_done", W'(done), W'(0));
        chk("abort_quo", quotient, '0);
        chk("abort_rem", remainder, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_op(64'd1000, 64'd9, "post_rst");

        for (int i = 0; i < 1000; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 4 == 1) b = W'($urandom_range(1, 1000));
            if (i % 4 == 2) b = {32'd0, $urandom};
            if (i % 4 == 3) a = {32'd0, $urandom};
            run_op(a, b, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/non_restoring_divisor.md
# non_restoring_divisor

Multi-cycle unsigned integer divider using the non-restoring algorithm, producing quotient and remainder of two WIDTH-bit operands. Serves as the DIV/DIVU/REM/REMU backend of the RV64 execute stage. It retires one quotient bit per clock and signals completion with a level `done` flag that holds until the next operation is launched.

## Interface
- `WIDTH`, default 64: operand, quotient and remainder width.
- `clk`  input  1: rising-edge clock.
- `rst`  input  1: synchronous, active-high reset.
- `start`  input  1: launch request; a new operation starts on a rising edge of `start`.
- `dividend`  input  WIDTH: unsigned numerator, sampled at launch.
- `divisor`  input  WIDTH: unsigned denominator, sampled at launch.
- `quotient`  output  WIDTH: dividend / divisor, valid while `done`=1.
- `remainder`  output  WIDTH: dividend % divisor, valid while `done`=1.
- `done`  output  1: result valid; held high until the next launch or reset.

## Operation
- Launch condition: `start`=1 and registered `start_q`=0, in IDLE or DONE. Holding `start` high launches exactly one operation. Launch conditions in RUN or FIX are ignored.
- At launch:
  - Latch both operands.
  - Clear the partial remainder P (WIDTH+1 bits, signed) to 0.
  - Load Q with the dividend.
  - Clear the counter and `done`.
- States: IDLE → RUN on launch; RUN → FIX after WIDTH iterations; FIX → DONE; DONE → RUN on launch. Any state → IDLE on `rst`.
- RUN step, one per cycle:
  - Shift {P,Q} left by 1.
  - If the old P ≥ 0, P = P − D; otherwise P = P + D.
  - Set Q[0] = ~P_new[sign].
- FIX: if P < 0, P = P + D. Then quotient = Q and remainder = P[WIDTH-1:0].
- Divisor 0: quotient = all ones, remainder = dividend. This matches RISC-V and falls out of the algorithm naturally.
- Outputs are registered. `quotient` and `remainder` keep their last result until the next FIX.
- Reset sets all outputs to 0, `done` = 0, state = IDLE and `start_q` = 0. Reset mid-operation aborts the operation with no result.

## Timing
- Launch sampled at edge 0.
- RUN occupies edges 1..WIDTH; FIX is at edge WIDTH+1.
- `done` rises after edge WIDTH+2, giving 66 cycles for WIDTH=64.
- `done` falls after the launch edge, so it is low one cycle after a new `start` rises.
- Back-to-back use: `start` must return low for at least one cycle between operations.

## Configuration
- `NON_RESTORING_DIVISOR_ZERO_BYPASS_EN` defined:
  - A launch with divisor 0 goes directly to DONE on the next edge.
  - Results: quotient = all ones, remainder = dividend; latency 1 cycle.
- Macro undefined: divisor 0 runs the full WIDTH+2 cycle sequence and gives the same results.

## Structure
- Package `non_restoring_divisor_pkg`: state enum typedef (IDLE, RUN, FIX, DONE) and default width constant 64.
- One sub-module, `nrd_addsub`: a WIDTH+1-bit add/subtract selected by the sign of P.
- Counter width: $clog2(WIDTH+1).

## Test plan
- dividend 100, divisor 7 → quotient 14, remainder 2; `done` rises 66 cycles after launch.
- dividend 5, divisor 0xFFFF_FFFF_FFFF_FFFF → quotient 0, remainder 5.
- dividend 0xFFFF_FFFF_FFFF_FFFF, divisor 1 → quotient all ones, remainder 0.
- dividend 0x1234, divisor 0 → quotient all ones, remainder 0x1234.
  - Latency 1 cycle with the bypass macro defined, 66 cycles without.
- 1000 random 64-bit operand pairs, each with `start` held high until `done`, then low 5 cycles → every result equals the reference / and %. Verify `done` is low one cycle after each launch.
- Assert `rst` midway through an operation → `done`=0 and outputs 0 next cycle; a subsequent launch completes correctly.
